// File: rtl/sat_add_pkg.sv
// Shared types and helpers for the saturating-add arbiter.
// State enum, saturation bound functions and stats width.
package sat_add_pkg;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  localparam int STAT_W = 16;

  function automatic int SAT_MAX(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int SAT_MIN(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/sat_add_core.sv
// Combinational signed add with clamp to an OUT_W-bit range.
// The add is done one bit wider so it never overflows.
module sat_add_core
  import sat_add_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  a_i,
  input  logic [IN_W-1:0]  b_i,
  output logic [OUT_W-1:0] sum_o,
  output logic             sat_o
);

  localparam int W1   = IN_W + 1;
  localparam int MAXI = SAT_MAX(OUT_W);
  localparam int MINI = SAT_MIN(OUT_W);
  localparam logic signed [IN_W:0] MAXV = W1'(MAXI);
  localparam logic signed [IN_W:0] MINV = W1'(MINI);

  logic signed [IN_W:0] temp;

  assign temp = $signed({a_i[IN_W-1], a_i})
              + $signed({b_i[IN_W-1], b_i});

  // Clamp the wide sum into the output range
  always_comb begin
    sum_o = temp[OUT_W-1:0];
    sat_o = 1'b0;
    if (temp > MAXV) begin
      sum_o = OUT_W'(MAXI);
      sat_o = 1'b1;
    end else if (temp < MINV) begin
      sum_o = OUT_W'(MINI);
      sat_o = 1'b1;
    end
  end

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin share of one saturating adder, registered output.
// Optional clamp counter: SAT_ADD_ARB_STATS_EN.
module sat_add_arbiter
  import sat_add_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 32,
  parameter int OUT_W   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*IN_W-1:0] req_a,
  input  logic [NUM_REQ*IN_W-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [OUT_W-1:0]        res_sum,
  output logic [ID_W-1:0]         res_id,
  output logic                    res_sat,
  output logic [STAT_W-1:0]       sat_count
);

  state_e state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             sat_q, sat_d;

  logic             free;
  logic             gnt;
  int               gnt_idx;
  logic [IN_W-1:0]  op_a, op_b;
  logic [OUT_W-1:0] core_sum;
  logic             core_sat;

  assign free = (state_q == ST_EMPTY) | res_ready;

  // Pick the first valid requester at or after rr_ptr
  always_comb begin
    req_ready = '0;
    gnt       = 1'b0;
    gnt_idx   = 0;
    if (free && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt &&
            req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
          gnt     = 1'b1;
          gnt_idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        end
      end
    end
    if (gnt) req_ready[gnt_idx] = 1'b1;
  end

  assign op_a = req_a[gnt_idx*IN_W +: IN_W];
  assign op_b = req_b[gnt_idx*IN_W +: IN_W];

  sat_add_core #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_core (
    .a_i  (op_a),
    .b_i  (op_b),
    .sum_o(core_sum),
    .sat_o(core_sat)
  );

  // Next state, pointer and result register load
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sum_d    = sum_q;
    id_d     = id_q;
    sat_d    = sat_q;
    if (gnt) begin
      state_d  = ST_FULL;
      rr_ptr_d = ID_W'((gnt_idx + 1) % NUM_REQ);
      sum_d    = core_sum;
      id_d     = ID_W'(gnt_idx);
      sat_d    = core_sat;
    end else if (state_q == ST_FULL && res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State, pointer and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      sum_q    <= '0;
      id_q     <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sum_q    <= sum_d;
      id_q     <= id_d;
      sat_q    <= sat_d;
    end
  end

  assign res_valid = (state_q == ST_FULL);
  assign res_sum   = sum_q;
  assign res_id    = id_q;
  assign res_sat   = sat_q;

`ifdef SAT_ADD_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q, cnt_d;

  // Count every accepted pair that clamped
  always_comb begin
    cnt_d = cnt_q;
    if (gnt && core_sat) cnt_d = cnt_q + 1'b1;
  end

  // Stats counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign sat_count = cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule
